dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's memory stage; the slave end of the core's address/write-data/write-enable/read-data interface.
- Contains word RAM, a memory-mapped free-running cycle counter, a byte transmit FIFO drained by a valid/ready handshake, and sticky error flags.
- Read data is combinational, so the core captures it into its writeback register in the same cycle.
- Writes commit on the rising clock edge.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of 2.
- FIFO_DEPTH, 4, transmit FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- memwrite  input  1  write enable from the core's memory stage.
- addr  input  32  byte address (core ALU result, memory stage).
- writedata  input  32  store data.
- readdata  output  32  combinational read data for addr.
- tx_valid  output  1  FIFO non-empty.
- tx_data  output  8  FIFO head byte.
- tx_ready  input  1  consumer accepts the head byte.
- err  output  3  sticky errors: bit0 misaligned write, bit1 TX overflow, bit2 unmapped write.

Behaviour:

Address map (word index = addr[31:2]; reads ignore addr[1:0]):
- addr[31:28]==4'h0: RAM. Index is addr[log2(RAM_WORDS)+1:2]; upper bits are aliased.
- 0xFFFF_0000 TXDATA: a write pushes writedata[7:0]; a read returns 0.
- 0xFFFF_0004 TXSTAT: a read returns {30'b0, full, empty}; writes are ignored with no error.
- 0xFFFF_0008 CYCLE: a read returns the counter; a write loads writedata.
- 0xFFFF_000C ERR: a read returns {29'b0, err}; any write clears all err bits.
- Any other address: a read returns 0; a write is ignored and sets err[2].

Reads:
- Purely combinational and evaluated every cycle, because the core drives addr for every instruction. Reads never set errors.
- Read-during-write to the same location returns the pre-edge value.

Writes (memwrite=1, rising edge):
- If addr[1:0]!=0: the write is suppressed, err[0] is set, and no other effect occurs.
- RAM write replaces the full word. Writes take one edge; there is no stall or backpressure to the core.

Cycle counter:
- 32-bit; increments by 1 every cycle and wraps 0xFFFF_FFFF to 0.
- In a CYCLE-write cycle the counter takes writedata (no increment that edge) and resumes incrementing the next edge.

TX FIFO:
- Circular buffer with read/write pointers and an occupancy count of width log2(FIFO_DEPTH)+1.
- tx_valid = (count != 0); tx_data = head entry.
- Pop occurs on an edge where tx_valid && tx_ready.
- Push (TXDATA write) is accepted if not full, or if full and a pop occurs the same edge; count is then unchanged.
- A push while full with no pop drops the byte and sets err[1]; FIFO contents are unchanged.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- tx_ready while empty has no effect.
- tx_data is held stable while tx_valid && !tx_ready.

Errors:
- err bits are sticky until reset or an ERR write.
- If an ERR write coincides with an error event, the clear wins. An ERR write can itself only be aligned, so no event from the same access exists.

Reset (reset_n low at an edge):
- Counter 0, FIFO empty (tx_valid=0, tx_data=0), err=0.
- Reset dominates any simultaneous write or pop.
- RAM contents are not cleared; they are undefined until written. Simulation models initialise RAM to 0.
- After reset, reads of TXSTAT return 1 and reads of CYCLE return the counter value.

Test Plan:
- Reset released; write 0xDEADBEEF to 0x0000_0010, then read 0x10 and 0x13 -> readdata=0xDEADBEEF both times, err=0; write to 0x0000_0110 with RAM_WORDS=64 aliases to word 4.
- Write 0x1234 to 0x0000_0012 -> RAM word 4 unchanged, err=3'b001; write to 0xFFFF_000C -> err=0; write to 0x8000_0000 -> err=3'b100.
- tx_ready=0; push 0x41,0x42,0x43,0x44,0x45 -> TXSTAT reads 2 (full) after the 4th push, the 5th is dropped, err[1]=1; raise tx_ready -> bytes 41,42,43,44 appear in order over 4 cycles, then tx_valid=0 and TXSTAT=1.
- With FIFO full and tx_ready=1, push 0x55 on the same edge as a pop -> accepted, count stays 4, err[1] stays 0, and 0x55 emerges last.
- Read CYCLE on two consecutive cycles -> values differ by 1; write 0xFFFF_FFFE -> subsequent reads give 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Drive reset_n low for one edge mid-drain with err set and the counter nonzero -> next cycle tx_valid=0, err=0, counter=0, while a previously written RAM word still reads back intact in a model that retains contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Memory-stage data responder: word RAM, cycle counter, byte TX FIFO and sticky error flags.
// Reads are combinational on addr; every write commits on the rising edge with no stall to the core.
module dmem_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [2:0]  err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [29:0] W_TXDATA = 30'h3FFF_C000;
  localparam logic [29:0] W_TXSTAT = 30'h3FFF_C001;
  localparam logic [29:0] W_CYCLE  = 30'h3FFF_C002;
  localparam logic [29:0] W_ERR    = 30'h3FFF_C003;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [2:0]    err_q, err_d;

  logic [29:0]   word;
  logic [AW-1:0] ram_idx;
  logic          is_ram, hit_txdata, hit_txstat, hit_cycle, hit_err;
  logic          aligned, wr_en, full, empty;
  logic          pop, push_req, push, overflow, unmapped;

  assign word       = addr[31:2];
  assign ram_idx    = addr[AW+1:2];
  assign is_ram     = (addr[31:28] == 4'h0);
  assign hit_txdata = (word == W_TXDATA);
  assign hit_txstat = (word == W_TXSTAT);
  assign hit_cycle  = (word == W_CYCLE);
  assign hit_err    = (word == W_ERR);

  // A misaligned store is dropped entirely; only err[0] records it.
  assign aligned  = (addr[1:0] == 2'b00);
  assign wr_en    = memwrite && aligned;
  assign unmapped = wr_en && !(is_ram || hit_txdata || hit_txstat || hit_cycle || hit_err);

  assign full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop      = !empty && tx_ready;
  assign push_req = wr_en && hit_txdata;
  assign push     = push_req && (!full || pop);
  assign overflow = push_req && full && !pop;

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - (PW+1)'(1);
    end
    cycle_d = (wr_en && hit_cycle) ? writedata : cycle_q + 32'd1;
    // Clearing wins over any error raised in the same cycle.
    err_d   = (wr_en && hit_err) ? 3'b000
                                 : (err_q | {unmapped, overflow, memwrite && !aligned});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      cycle_q  <= '0;
      err_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      cycle_q  <= cycle_d;
      err_q    <= err_d;
    end
  end

  // Storage arrays are never cleared; reset only blocks a coincident write.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en && is_ram) begin
      ram_q[ram_idx] <= writedata;
    end
    if (reset_n && push) begin
      fifo_q[wr_ptr_q] <= writedata[7:0];
    end
  end

  always_comb begin
    readdata = '0;
    if (is_ram) begin
      readdata = ram_q[ram_idx];
    end else begin
      case (word)
        W_TXSTAT: readdata = {30'b0, full, empty};
        W_CYCLE:  readdata = cycle_q;
        W_ERR:    readdata = {29'b0, err_q};
        default:  readdata = '0;
      endcase
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table plus hand-written counter and reset sequences.
module tb_dmem_responder;

  localparam logic [31:0] TXD = 32'hFFFF_0000;
  localparam logic [31:0] TXS = 32'hFFFF_0004;
  localparam logic [31:0] CYC = 32'hFFFF_0008;
  localparam logic [31:0] ERA = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [2:0]  err;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rdy;
    logic        ck_rd;
    logic [31:0] rd;
    logic [2:0]  e;
    logic        v;
    logic [7:0]  d;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                              input logic rdy, input logic ck_rd, input logic [31:0] rd,
                              input logic [2:0] e, input logic v, input logic [7:0] d);
    vec_t x;
    x.mw = mw; x.a = a; x.wd = wd; x.rdy = rdy; x.ck_rd = ck_rd;
    x.rd = rd; x.e = e; x.v = v; x.d = d;
    vt.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // New inputs appear just after a rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic rst, input logic mw, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy);
    @(posedge clk);
    #1;
    reset_n = rst; memwrite = mw; addr = a; writedata = wd; tx_ready = rdy;
    @(negedge clk);
  endtask

  logic [31:0] c1;

  initial begin
    reset_n = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);

    //   mw  addr          wdata          rdy ck  readdata       err     vld data
    add(0, TXS,           0,             0,  1,  32'h1,         3'b000, 0, 8'h00);
    add(1, 32'h10,        32'hDEADBEEF,  0,  0,  0,             3'b000, 0, 8'h00);
    add(0, 32'h10,        0,             0,  1,  32'hDEADBEEF,  3'b000, 0, 8'h00);
    add(0, 32'h13,        0,             0,  1,  32'hDEADBEEF,  3'b000, 0, 8'h00);
    add(0, 32'h110,       0,             0,  1,  32'hDEADBEEF,  3'b000, 0, 8'h00);
    add(1, 32'h110,       32'hCAFEF00D,  0,  1,  32'hDEADBEEF,  3'b000, 0, 8'h00);
    add(0, 32'h10,        0,             0,  1,  32'hCAFEF00D,  3'b000, 0, 8'h00);
    add(1, 32'h12,        32'h1234,      0,  1,  32'hCAFEF00D,  3'b000, 0, 8'h00);
    add(0, 32'h10,        0,             0,  1,  32'hCAFEF00D,  3'b001, 0, 8'h00);
    add(0, ERA,           0,             0,  1,  32'h1,         3'b001, 0, 8'h00);
    add(1, ERA,           32'h5,         0,  1,  32'h1,         3'b001, 0, 8'h00);
    add(0, ERA,           0,             0,  1,  32'h0,         3'b000, 0, 8'h00);
    add(1, 32'h8000_0000, 32'h5,         0,  1,  32'h0,         3'b000, 0, 8'h00);
    add(0, ERA,           0,             0,  1,  32'h4,         3'b100, 0, 8'h00);
    add(1, TXS,           32'h7,         0,  1,  32'h1,         3'b100, 0, 8'h00);
    add(0, ERA,           0,             0,  1,  32'h4,         3'b100, 0, 8'h00);
    add(1, ERA,           0,             0,  1,  32'h4,         3'b100, 0, 8'h00);
    // fill to full, overflow, then drain
    add(1, TXD,           32'h41,        0,  1,  32'h0,         3'b000, 0, 8'h00);
    add(1, TXD,           32'h42,        0,  1,  32'h0,         3'b000, 1, 8'h41);
    add(1, TXD,           32'h43,        0,  1,  32'h0,         3'b000, 1, 8'h41);
    add(1, TXD,           32'h44,        0,  1,  32'h0,         3'b000, 1, 8'h41);
    add(0, TXS,           0,             0,  1,  32'h2,         3'b000, 1, 8'h41);
    add(1, TXD,           32'h45,        0,  1,  32'h0,         3'b000, 1, 8'h41);
    add(0, ERA,           0,             0,  1,  32'h2,         3'b010, 1, 8'h41);
    add(0, TXS,           0,             1,  1,  32'h2,         3'b010, 1, 8'h41);
    add(0, TXS,           0,             1,  1,  32'h0,         3'b010, 1, 8'h42);
    add(0, TXS,           0,             1,  1,  32'h0,         3'b010, 1, 8'h43);
    add(0, TXS,           0,             1,  1,  32'h0,         3'b010, 1, 8'h44);
    add(0, TXS,           0,             1,  1,  32'h1,         3'b010, 0, 8'h00);
    add(1, ERA,           0,             0,  1,  32'h2,         3'b010, 0, 8'h00);
    // push into a full FIFO on the same edge as a pop
    add(1, TXD,           32'h51,        0,  1,  32'h0,         3'b000, 0, 8'h00);
    add(1, TXD,           32'h52,        0,  1,  32'h0,         3'b000, 1, 8'h51);
    add(1, TXD,           32'h53,        0,  1,  32'h0,         3'b000, 1, 8'h51);
    add(1, TXD,           32'h54,        0,  1,  32'h0,         3'b000, 1, 8'h51);
    add(1, TXD,           32'h55,        1,  1,  32'h0,         3'b000, 1, 8'h51);
    add(0, TXS,           0,             0,  1,  32'h2,         3'b000, 1, 8'h52);
    add(0, TXS,           0,             1,  1,  32'h2,         3'b000, 1, 8'h52);
    add(0, TXS,           0,             1,  1,  32'h0,         3'b000, 1, 8'h53);
    add(0, TXS,           0,             1,  1,  32'h0,         3'b000, 1, 8'h54);
    add(0, TXS,           0,             1,  1,  32'h0,         3'b000, 1, 8'h55);
    add(0, TXS,           0,             1,  1,  32'h1,         3'b000, 0, 8'h00);
    add(1, 32'hFFFF_0001, 32'h66,        0,  1,  32'h0,         3'b000, 0, 8'h00);
    add(0, TXS,           0,             0,  1,  32'h1,         3'b001, 0, 8'h00);

    for (int i = 0; i < vt.size(); i++) begin
      drive(1'b1, vt[i].mw, vt[i].a, vt[i].wd, vt[i].rdy);
      if (vt[i].ck_rd) check($sformatf("v%0d readdata", i), readdata, vt[i].rd);
      check($sformatf("v%0d err", i), {29'b0, err}, {29'b0, vt[i].e});
      check($sformatf("v%0d tx_valid", i), {31'b0, tx_valid}, {31'b0, vt[i].v});
      check($sformatf("v%0d tx_data", i), {24'b0, tx_data}, {24'b0, vt[i].d});
    end

    // cycle counter: consecutive reads, load, wrap
    drive(1'b1, 1'b0, CYC, 0, 1'b0);
    c1 = readdata;
    drive(1'b1, 1'b0, CYC, 0, 1'b0);
    check("cycle step", readdata, c1 + 32'd1);
    drive(1'b1, 1'b1, CYC, 32'hFFFF_FFFE, 1'b0);
    drive(1'b1, 1'b0, CYC, 0, 1'b0);
    check("cycle load", readdata, 32'hFFFF_FFFE);
    drive(1'b1, 1'b0, CYC, 0, 1'b0);
    check("cycle max", readdata, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, CYC, 0, 1'b0);
    check("cycle wrap", readdata, 32'h0);

    // reset mid-drain with errors pending
    drive(1'b1, 1'b1, 32'h20, 32'h1111_2222, 1'b0);
    drive(1'b1, 1'b1, 32'hFFFF_0002, 0, 1'b0);
    drive(1'b1, 1'b1, TXD, 32'h77, 1'b0);
    drive(1'b1, 1'b1, TXD, 32'h78, 1'b0);
    drive(1'b1, 1'b0, CYC, 0, 1'b1);
    check("pre-reset err", {29'b0, err}, 32'h1);
    check("pre-reset valid", {31'b0, tx_valid}, 32'h1);
    check("pre-reset cycle nonzero", {31'b0, readdata != 32'h0}, 32'h1);
    drive(1'b0, 1'b1, TXD, 32'h79, 1'b1);
    drive(1'b1, 1'b0, CYC, 0, 1'b0);
    check("post-reset valid", {31'b0, tx_valid}, 32'h0);
    check("post-reset data", {24'b0, tx_data}, 32'h0);
    check("post-reset err", {29'b0, err}, 32'h0);
    check("post-reset cycle", readdata, 32'h0);
    drive(1'b1, 1'b0, TXS, 0, 1'b0);
    check("post-reset txstat", readdata, 32'h1);
    drive(1'b1, 1'b0, 32'h20, 0, 1'b0);
    check("ram retained", readdata, 32'h1111_2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
